// File: rtl/drm_bus_license_responder_pkg.sv
// Shared register map, bit indices and FSM state types for the DRM bus license responder.
package drm_bus_license_responder_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_LIC    = 1;
  localparam int ADDR_STATUS = 2;
  localparam int ADDR_EXP    = 3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLR_INT = 2;

  localparam int STAT_BUSY  = 8;
  localparam int STAT_DONE  = 9;
  localparam int STAT_ERROR = 10;
  localparam int STAT_OVF   = 11;
  localparam int STAT_CSUM  = 12;

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK, B_END} bus_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} load_state_t;

endpackage

// File: rtl/drm_license_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level; pointers carry one extra wrap bit.
module drm_license_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/drm_bus_license_responder.sv
// DRM controller bus responder: buffers license words and streams them to the activator.
// Optional macro DRM_LICENSE_CHECKSUM_EN: last expected word is an XOR checksum of the others.
module drm_bus_license_responder
  import drm_bus_license_responder_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ACK_WAIT   = 1
) (
  input  logic              drm_aclk,
  input  logic              drm_arst,
  input  logic              drm_bus_slave_i_cs,
  input  logic              drm_bus_slave_i_cyc,
  input  logic              drm_bus_slave_i_we,
  input  logic [ADDR_W-1:0] drm_bus_slave_i_adr,
  input  logic [DATA_W-1:0] drm_bus_slave_i_dat,
  output logic              drm_bus_slave_o_ack,
  output logic              drm_bus_slave_o_sta,
  output logic              drm_bus_slave_o_intr,
  output logic [DATA_W-1:0] drm_bus_slave_o_dat,
  output logic              lic_tvalid,
  output logic [DATA_W-1:0] lic_tdata,
  input  logic              lic_tready,
  output logic              lic_done
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  bus_state_t        bus_q, bus_d;
  logic [3:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [DATA_W-1:0] dat_q;
  logic              req, ack;

  load_state_t       load_q, load_d;
  logic [15:0]       sent_q, sent_d, exp_q;
  logic              intr_q, intr_d, ovf_q;

  logic              wr, wr_ctrl, lic_wr, exp_wr, status_wr;
  logic              start, abort, clr_int, lic_ovf, lic_rej, sta_c;
  logic [DATA_W-1:0] rd_data;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fwd, avail;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic              load_done_hit;

`ifdef DRM_LICENSE_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q;
  logic              csum_fail_q, csum_bad;
`endif

  assign req = drm_bus_slave_i_cs & drm_bus_slave_i_cyc;
  assign ack = (bus_q == B_ACK);

  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      bus_q  <= B_IDLE;
      wait_q <= '0;
    end else begin
      bus_q  <= bus_d;
      wait_q <= wait_d;
    end
  end

  always_ff @(posedge drm_aclk) begin
    if (bus_q == B_IDLE && req) begin
      adr_q <= drm_bus_slave_i_adr;
      we_q  <= drm_bus_slave_i_we;
      dat_q <= drm_bus_slave_i_dat;
    end
  end

  always_comb begin
    bus_d  = bus_q;
    wait_d = wait_q;
    case (bus_q)
      B_IDLE: if (req) begin
        wait_d = '0;
        bus_d  = (ACK_WAIT == 0) ? B_ACK : B_WAIT;
      end
      B_WAIT: begin
        if (!req)                             bus_d  = B_IDLE;
        else if (wait_q == 4'(ACK_WAIT - 1))  bus_d  = B_ACK;
        else                                  wait_d = wait_q + 4'd1;
      end
      B_ACK:  bus_d = B_END;
      B_END:  if (!drm_bus_slave_i_cyc) bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  // Register side effects commit in the ack cycle only, so aborted transfers leave no trace.
  assign wr        = ack & we_q;
  assign wr_ctrl   = wr & (adr_q == ADDR_W'(ADDR_CTRL));
  assign lic_wr    = wr & (adr_q == ADDR_W'(ADDR_LIC));
  assign status_wr = wr & (adr_q == ADDR_W'(ADDR_STATUS));
  assign exp_wr    = wr & (adr_q == ADDR_W'(ADDR_EXP));
  assign start     = wr_ctrl & dat_q[CTRL_START];
  assign abort     = wr_ctrl & dat_q[CTRL_ABORT];
  assign clr_int   = wr_ctrl & dat_q[CTRL_CLR_INT];
  assign lic_rej   = lic_wr & (load_q != LOAD);
  assign lic_ovf   = lic_wr & (load_q == LOAD) & fifo_full & ~fifo_pop;
  assign fifo_push = lic_wr & (load_q == LOAD) & ~lic_ovf;
  assign sta_c     = status_wr | (exp_wr & (load_q != IDLE)) | lic_rej | lic_ovf;

  always_comb begin
    rd_data = '0;
    if (adr_q == ADDR_W'(ADDR_STATUS)) begin
      rd_data[7:0]        = 8'(fifo_level);
      rd_data[STAT_BUSY]  = (load_q == LOAD);
      rd_data[STAT_DONE]  = (load_q == DONE);
      rd_data[STAT_ERROR] = (load_q == ERROR);
      rd_data[STAT_OVF]   = ovf_q;
`ifdef DRM_LICENSE_CHECKSUM_EN
      rd_data[STAT_CSUM]  = csum_fail_q;
`endif
    end else if (adr_q == ADDR_W'(ADDR_EXP)) begin
      rd_data = DATA_W'(exp_q);
    end
  end

  assign drm_bus_slave_o_ack  = ack;
  assign drm_bus_slave_o_sta  = sta_c;
  assign drm_bus_slave_o_dat  = (ack && !we_q) ? rd_data : '0;
  assign drm_bus_slave_o_intr = intr_q;

  drm_license_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (drm_aclk),
    .rst   (drm_arst),
    .flush (abort),
    .push  (fifo_push),
    .din   (dat_q),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // The checksum word is consumed internally instead of being offered to the activator.
`ifdef DRM_LICENSE_CHECKSUM_EN
  assign fwd      = (sent_q != exp_q - 16'd1);
  assign csum_bad = (fifo_head != xor_q);
`else
  assign fwd      = 1'b1;
`endif
  assign avail         = (load_q == LOAD) & ~fifo_empty;
  assign lic_tvalid    = avail & fwd;
  assign lic_tdata     = lic_tvalid ? fifo_head : '0;
  assign fifo_pop      = avail & (fwd ? lic_tready : 1'b1);
  assign lic_done      = (load_q == DONE);
  assign load_done_hit = fifo_pop & (sent_q + 16'd1 == exp_q);

  always_comb begin
    load_d = load_q;
    sent_d = sent_q;
    intr_d = clr_int ? 1'b0 : intr_q;
    case (load_q)
      IDLE: if (start) begin
        sent_d = '0;
        if (exp_q != '0) load_d = LOAD;
        else begin
          load_d = ERROR;
          intr_d = 1'b1;
        end
      end
      LOAD: if (fifo_pop) begin
        sent_d = sent_q + 16'd1;
        if (load_done_hit) begin
          intr_d = 1'b1;
`ifdef DRM_LICENSE_CHECKSUM_EN
          load_d = csum_bad ? ERROR : DONE;
`else
          load_d = DONE;
`endif
        end
      end
      DONE: if (start) begin
        sent_d = '0;
        load_d = LOAD;
      end
      default: ;
    endcase
    if (abort) begin
      load_d = IDLE;
      sent_d = '0;
      intr_d = 1'b0;
    end
  end

  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      load_q <= IDLE;
      sent_q <= '0;
      intr_q <= 1'b0;
      ovf_q  <= 1'b0;
      exp_q  <= '0;
    end else begin
      load_q <= load_d;
      sent_q <= sent_d;
      intr_q <= intr_d;
      if (abort)        ovf_q <= 1'b0;
      else if (lic_ovf) ovf_q <= 1'b1;
      if (exp_wr && load_q == IDLE) exp_q <= dat_q[15:0];
    end
  end

`ifdef DRM_LICENSE_CHECKSUM_EN
  always_ff @(posedge drm_aclk) begin
    if (drm_arst || abort) begin
      xor_q       <= '0;
      csum_fail_q <= 1'b0;
    end else begin
      if (start) xor_q <= '0;
      else if (fifo_pop && fwd) xor_q <= xor_q ^ fifo_head;
      if (load_done_hit && csum_bad) csum_fail_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_drm_bus_license_responder.sv
// Directed self-checking bench for drm_bus_license_responder (ACK_WAIT = 3).
module tb_drm_bus_license_responder;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cs = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [1:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic        ack, sta, intr, tvalid, done;
  logic [31:0] rdat, tdata;
  logic        tready = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] cap[$];

  drm_bus_license_responder #(
    .ADDR_W(2), .DATA_W(32), .FIFO_DEPTH(16), .ACK_WAIT(3)
  ) dut (
    .drm_aclk             (clk),
    .drm_arst             (arst),
    .drm_bus_slave_i_cs   (cs),
    .drm_bus_slave_i_cyc  (cyc),
    .drm_bus_slave_i_we   (we),
    .drm_bus_slave_i_adr  (adr),
    .drm_bus_slave_i_dat  (wdat),
    .drm_bus_slave_o_ack  (ack),
    .drm_bus_slave_o_sta  (sta),
    .drm_bus_slave_o_intr (intr),
    .drm_bus_slave_o_dat  (rdat),
    .lic_tvalid           (tvalid),
    .lic_tdata            (tdata),
    .lic_tready           (tready),
    .lic_done             (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tvalid && tready) cap.push_back(tdata);

  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input int hold, input bit tr_on_ack,
                      output logic [31:0] rd, output logic st, output int lat, output int extra);
    bit got = 0;
    rd = '0; st = 1'b0; lat = 0; extra = 0;
    cs = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1;
        lat = i;
        if (tr_on_ack) begin tready = 1'b1; #1; end
        rd = rdat;
        st = sta;
      end
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL xfer_timeout adr=%0d: no ack within 20 cycles", a);
    end
    if (tr_on_ack) begin @(posedge clk); #1; tready = 1'b0; end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    cs = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output logic st);
    logic [31:0] r; int l, e;
    xfer(1'b1, a, d, 0, 1'b0, r, st, l, e);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    logic st; int l, e;
    xfer(1'b0, a, '0, 0, 1'b0, r, st, l, e);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    compared++;
    if ({ack, sta, intr, rdat, tvalid, tdata, done} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h want=0", {ack, sta, intr, rdat, tvalid, tdata, done});
    end
    rd(2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL reset_status got=%h want=0", r); end
    rd(3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL reset_exp got=%h want=0", r); end
  endtask

  task automatic test_basic_load;
    logic st; logic [31:0] r;
    logic [31:0] ew[3] = '{32'hA1, 32'hB2, 32'hC3};
    cap.delete();
    tready = 1'b1;
    wr(3, 32'd3, st);
    wr(0, 32'h1, st);
    for (int i = 0; i < 3; i++) wr(1, ew[i], st);
    compared++;
    if (cap.size() !== 3) begin mismatched++; $display("FAIL basic_count got=%0d want=3", cap.size()); end
    for (int i = 0; i < 3; i++) begin
      r = (i < cap.size()) ? cap[i] : 32'hDEAD_DEAD;
      compared++;
      if (r !== ew[i]) begin mismatched++; $display("FAIL basic_word%0d got=%h want=%h", i, r, ew[i]); end
    end
    compared++;
    if ({done, intr} !== 2'b11) begin mismatched++; $display("FAIL basic_done_intr got=%b want=11", {done, intr}); end
    rd(2, r);
    compared++;
    if (r !== 32'h200) begin mismatched++; $display("FAIL basic_status got=%h want=200", r); end
    wr(1, 32'hEE, st);
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL extra_word_sta got=%b want=1", st); end
    wr(0, 32'h4, st);
    compared++;
    if ({done, intr} !== 2'b10) begin mismatched++; $display("FAIL clr_int got=%b want=10", {done, intr}); end
    wr(0, 32'h2, st);
    tready = 1'b0;
  endtask

`ifdef DRM_LICENSE_CHECKSUM_EN
  task automatic test_checksum;
    logic st; logic [31:0] r;
    cap.delete();
    tready = 1'b1;
    wr(3, 32'd3, st);
    wr(0, 32'h1, st);
    wr(1, 32'h1, st); wr(1, 32'h2, st); wr(1, 32'h3, st);
    compared++;
    if (cap.size() !== 2 || cap[0] !== 32'h1 || cap[1] !== 32'h2) begin
      mismatched++; $display("FAIL csum_fwd got_n=%0d want 2 words 1,2", cap.size());
    end
    rd(2, r);
    compared++;
    if (r !== 32'h200) begin mismatched++; $display("FAIL csum_ok_status got=%h want=200", r); end
    wr(0, 32'h2, st);
    wr(0, 32'h1, st);
    wr(1, 32'h1, st); wr(1, 32'h2, st); wr(1, 32'h4, st);
    rd(2, r);
    compared++;
    if (r !== 32'h1400) begin mismatched++; $display("FAIL csum_bad_status got=%h want=1400", r); end
    wr(0, 32'h2, st);
    rd(2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL csum_abort_status got=%h want=0", r); end
    tready = 1'b0;
  endtask
`endif

  task automatic test_overflow;
    logic st; logic [31:0] r; int nsta, l, e;
    cap.delete();
    tready = 1'b0;
    wr(3, 32'd20, st);
    wr(0, 32'h1, st);
    nsta = 0;
    for (int i = 0; i < 16; i++) begin
      wr(1, 32'h100 + i, st);
      if (st) nsta++;
    end
    compared++;
    if (nsta !== 0) begin mismatched++; $display("FAIL ovf_fill_sta got=%0d want=0", nsta); end
    wr(1, 32'h1FF, st);
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL ovf_17th_sta got=%b want=1", st); end
    rd(2, r);
    compared++;
    if (r !== 32'h910) begin mismatched++; $display("FAIL ovf_status got=%h want=910", r); end
    compared++;
    if ({tvalid, tdata} !== {1'b1, 32'h100}) begin
      mismatched++; $display("FAIL ovf_hold_head got=%b/%h want=1/100", tvalid, tdata);
    end
    xfer(1'b1, 2'd1, 32'h2AA, 0, 1'b1, r, st, l, e);
    compared++;
    if (st !== 1'b0) begin mismatched++; $display("FAIL full_push_pop_sta got=%b want=0", st); end
    rd(2, r);
    compared++;
    if (r !== 32'h910 || cap.size() !== 1) begin
      mismatched++; $display("FAIL full_push_pop_level got=%h/%0d want=910/1", r, cap.size());
    end
    wr(0, 32'h2, st);
    rd(2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL ovf_abort_status got=%h want=0", r); end
  endtask

  task automatic test_timing;
    logic st; logic [31:0] r; int l, e;
    xfer(1'b0, 2'd2, '0, 6, 1'b0, r, st, l, e);
    compared++;
    if (l !== 4) begin mismatched++; $display("FAIL ack_latency got=%0d want=4", l); end
    compared++;
    if (e !== 0) begin mismatched++; $display("FAIL held_cyc_extra_ack got=%0d want=0", e); end
    wr(3, 32'd7, st);
    cs = 1'b1; cyc = 1'b1; we = 1'b1; adr = 2'd3; wdat = 32'h55;
    e = 0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (ack) e++; end
    cyc = 1'b0; cs = 1'b0; we = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ack) e++; end
    compared++;
    if (e !== 0) begin mismatched++; $display("FAIL abort_xfer_ack got=%0d want=0", e); end
    rd(3, r);
    compared++;
    if (r !== 32'd7) begin mismatched++; $display("FAIL abort_xfer_exp got=%h want=7", r); end
  endtask

  task automatic test_bad_access;
    logic st; logic [31:0] r;
    wr(3, 32'd0, st);
    wr(0, 32'h1, st);
    rd(2, r);
    compared++;
    if ({intr, r} !== {1'b1, 32'h400}) begin
      mismatched++; $display("FAIL zero_exp_error got=%b/%h want=1/400", intr, r);
    end
    wr(2, 32'h1, st);
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL status_write_sta got=%b want=1", st); end
    wr(1, 32'h9, st);
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL lic_outside_load_sta got=%b want=1", st); end
    wr(0, 32'h2, st);
    rd(2, r);
    compared++;
    if ({intr, r} !== 33'h0) begin mismatched++; $display("FAIL error_abort got=%b/%h want=0/0", intr, r); end
    wr(3, 32'd5, st);
    wr(0, 32'h1, st);
    wr(3, 32'd9, st);
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL exp_write_busy_sta got=%b want=1", st); end
    rd(3, r);
    compared++;
    if (r !== 32'd5) begin mismatched++; $display("FAIL exp_write_busy_val got=%h want=5", r); end
    wr(0, 32'h2, st);
  endtask

  task automatic test_midload_reset;
    logic st; logic [31:0] r;
    tready = 1'b0;
    wr(3, 32'd4, st);
    wr(0, 32'h1, st);
    wr(1, 32'h11, st);
    wr(1, 32'h22, st);
    compared++;
    if ({tvalid, tdata} !== {1'b1, 32'h11}) begin
      mismatched++; $display("FAIL midload_head got=%b/%h want=1/11", tvalid, tdata);
    end
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    compared++;
    if ({ack, sta, intr, rdat, tvalid, tdata, done} !== '0) begin
      mismatched++; $display("FAIL midload_reset_outputs got=%h want=0", {ack, sta, intr, rdat, tvalid, tdata, done});
    end
    rd(2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL midload_reset_status got=%h want=0", r); end
    rd(3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL midload_reset_exp got=%h want=0", r); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    test_reset();
`ifdef DRM_LICENSE_CHECKSUM_EN
    test_checksum();
`else
    test_basic_load();
`endif
    test_overflow();
    test_timing();
    test_bad_access();
    test_midload_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
